aer_out_receiver: RTL and testbench

AER output-side responder for the spiking core: completes the 4-phase REQ/ACK handshake on the core's output AER bus and counts output spikes per class neuron over one sample. At sample end it performs a sequential argmax over the counters and reports the winning class. It sits between the core's AEROUT port and the classification/readout logic in the test top.

---
 rtl/aer_out_receiver_if.sv | 28 ++
 rtl/aer_out_receiver.sv | 188 ++++++++++++++++++
 tb/tb_aer_out_receiver.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aer_out_receiver_if.sv
// AEROUT handshake, control and classification-result bundle for aer_out_receiver.
// The core/test-top side uses the master modport; the receiver uses the slave modport.
interface aer_out_receiver_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8,
  parameter int CLS_W  = 4
);
  logic [ADDR_W-1:0] AEROUT_ADDR;
  logic              AEROUT_REQ;
  logic              AEROUT_ACK;
  logic              CLEAR;
  logic              SAMPLE_END;
  logic              CLASS_VALID;
  logic [CLS_W-1:0]  CLASS_ID;
  logic [CNT_W-1:0]  CLASS_CNT;
  logic [7:0]        DROP_CNT;
  logic              BUSY;

  modport master (
    output AEROUT_ADDR, AEROUT_REQ, CLEAR, SAMPLE_END,
    input  AEROUT_ACK, CLASS_VALID, CLASS_ID, CLASS_CNT, DROP_CNT, BUSY
  );

  modport slave (
    input  AEROUT_ADDR, AEROUT_REQ, CLEAR, SAMPLE_END,
    output AEROUT_ACK, CLASS_VALID, CLASS_ID, CLASS_CNT, DROP_CNT, BUSY
  );
endinterface

// File: rtl/aer_out_receiver.sv
// AER output responder: 4-phase ACK for core output events, per-class spike counting,
// sequential argmax at sample end. Define AER_REQ_SYNC_EN to add a 2-flop REQ synchroniser.
module aer_out_receiver #(
  parameter int ADDR_W    = 12,
  parameter int NUM_CLASS = 10,
  parameter int CNT_W     = 8,
  parameter int CLS_W     = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  aer_out_receiver_if.slave aer
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK_HI = 2'd1,
    SCAN   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CLS_W-1:0]  LAST_IDX    = CLS_W'(NUM_CLASS - 1);
  localparam logic [ADDR_W-1:0] NUM_CLASS_A = ADDR_W'(NUM_CLASS);

  state_t            state_q, state_d;
  logic              req_s;
  logic              ack_q, ack_d;
  logic              busy;
  logic              take_evt, enter_scan, scan_step, in_done;
  logic              scan_pend_q, scan_pend_d;
  logic [CLS_W-1:0]  idx_q, idx_d;
  logic [CLS_W-1:0]  best_id_q, best_id_d;
  logic [CNT_W-1:0]  best_cnt_q, best_cnt_d;
  logic [CLS_W-1:0]  class_id_q, class_id_d;
  logic [CNT_W-1:0]  class_cnt_q, class_cnt_d;
  logic              class_valid_q, class_valid_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CLASS];
  logic [CNT_W-1:0]  cnt_d [NUM_CLASS];
  logic [7:0]        drop_q, drop_d;
  logic [CNT_W-1:0]  scan_val;
  logic              addr_in_range;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_drop(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

`ifdef AER_REQ_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], aer.AEROUT_REQ};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  assign req_s = sync_q[1];
`else
  assign req_s = aer.AEROUT_REQ;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; a pending scan wins over a new request in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (scan_pend_q)  state_d = SCAN;
        else if (req_s)   state_d = ACK_HI;
      end
      ACK_HI: if (!req_s) state_d = IDLE;
      SCAN:   if (idx_q == LAST_IDX) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ACK is registered from the next state so it never glitches
  always_comb begin
    take_evt   = 1'b0;
    enter_scan = 1'b0;
    scan_step  = 1'b0;
    in_done    = 1'b0;
    busy       = 1'b1;
    ack_d      = (state_d == ACK_HI);
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        enter_scan = scan_pend_q;
        take_evt   = !scan_pend_q && req_s;
      end
      SCAN:    scan_step = 1'b1;
      DONE:    in_done   = 1'b1;
      default: ;
    endcase
  end

  assign addr_in_range = (aer.AEROUT_ADDR < NUM_CLASS_A);

  always_comb begin
    scan_val = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (idx_q == CLS_W'(k)) scan_val = cnt_q[k];
    end
  end

  // Scan bookkeeping and result capture
  always_comb begin
    scan_pend_d   = (scan_pend_q | aer.SAMPLE_END) & ~enter_scan;
    idx_d         = idx_q;
    best_id_d     = best_id_q;
    best_cnt_d    = best_cnt_q;
    class_id_d    = class_id_q;
    class_cnt_d   = class_cnt_q;
    class_valid_d = 1'b0;
    if (enter_scan) idx_d = '0;
    else if (scan_step) idx_d = idx_q + CLS_W'(1);
    if (scan_step && ((idx_q == '0) || (scan_val > best_cnt_q))) begin
      best_id_d  = idx_q;
      best_cnt_d = scan_val;
    end
    if (in_done) begin
      class_id_d    = best_id_q;
      class_cnt_d   = best_cnt_q;
      class_valid_d = 1'b1;
    end
  end

  // Counters; CLEAR overrides a same-cycle event, which is still acknowledged
  always_comb begin
    drop_d = drop_q;
    for (int k = 0; k < NUM_CLASS; k++) cnt_d[k] = cnt_q[k];
    if (aer.CLEAR) begin
      drop_d = '0;
      for (int k = 0; k < NUM_CLASS; k++) cnt_d[k] = '0;
    end else if (take_evt) begin
      if (addr_in_range) begin
        for (int k = 0; k < NUM_CLASS; k++) begin
          if (aer.AEROUT_ADDR == ADDR_W'(k)) cnt_d[k] = sat_inc_cnt(cnt_q[k]);
        end
      end else begin
        drop_d = sat_inc_drop(drop_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_q         <= 1'b0;
      scan_pend_q   <= 1'b0;
      idx_q         <= '0;
      best_id_q     <= '0;
      best_cnt_q    <= '0;
      class_id_q    <= '0;
      class_cnt_q   <= '0;
      class_valid_q <= 1'b0;
      drop_q        <= '0;
      for (int k = 0; k < NUM_CLASS; k++) cnt_q[k] <= '0;
    end else begin
      ack_q         <= ack_d;
      scan_pend_q   <= scan_pend_d;
      idx_q         <= idx_d;
      best_id_q     <= best_id_d;
      best_cnt_q    <= best_cnt_d;
      class_id_q    <= class_id_d;
      class_cnt_q   <= class_cnt_d;
      class_valid_q <= class_valid_d;
      drop_q        <= drop_d;
      for (int k = 0; k < NUM_CLASS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign aer.AEROUT_ACK  = ack_q;
  assign aer.CLASS_VALID = class_valid_q;
  assign aer.CLASS_ID    = class_id_q;
  assign aer.CLASS_CNT   = class_cnt_q;
  assign aer.DROP_CNT    = drop_q;
  assign aer.BUSY        = busy;

endmodule

// File: tb/tb_aer_out_receiver.sv
// Directed bench for aer_out_receiver in its default build (REQ used without synchroniser).
module tb_aer_out_receiver;

  localparam int ADDR_W    = 12;
  localparam int NUM_CLASS = 10;
  localparam int CNT_W     = 8;
  localparam int CLS_W     = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  aer_out_receiver_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .CLS_W(CLS_W)) bus ();

  aer_out_receiver #(
    .ADDR_W(ADDR_W), .NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W), .CLS_W(CLS_W)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .aer  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    bus.CLEAR = 1'b1;
    tick();
    bus.CLEAR = 1'b0;
  endtask

  // One complete handshake; each phase is bounded
  task automatic do_event(input logic [ADDR_W-1:0] addr);
    int n;
    bus.AEROUT_ADDR = addr;
    bus.AEROUT_REQ  = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.AEROUT_ACK && n < 20);
    checks++;
    if (bus.AEROUT_ACK !== 1'b1) begin
      failures++;
      $display("FAIL evt_ack_rise addr=%0d ack=%b required=1", addr, bus.AEROUT_ACK);
    end
    bus.AEROUT_REQ = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.AEROUT_ACK && n < 20);
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin
      failures++;
      $display("FAIL evt_ack_fall addr=%0d ack=%b required=0", addr, bus.AEROUT_ACK);
    end
  endtask

  // SAMPLE_END pulse, then latency, result and single-cycle valid
  task automatic run_scan(input string tag, input logic [CLS_W-1:0] exp_id,
                          input logic [CNT_W-1:0] exp_cnt);
    int n;
    bus.SAMPLE_END = 1'b1;
    tick();
    bus.SAMPLE_END = 1'b0;
    n = 0;
    while (!bus.CLASS_VALID && n < 40) begin tick(); n++; end
    checks++;
    if (n !== NUM_CLASS + 2) begin
      failures++;
      $display("FAIL %s_latency got=%0d required=%0d", tag, n, NUM_CLASS + 2);
    end
    checks++;
    if (bus.CLASS_ID !== exp_id) begin
      failures++;
      $display("FAIL %s_id got=%0d required=%0d", tag, bus.CLASS_ID, exp_id);
    end
    checks++;
    if (bus.CLASS_CNT !== exp_cnt) begin
      failures++;
      $display("FAIL %s_cnt got=%0d required=%0d", tag, bus.CLASS_CNT, exp_cnt);
    end
    tick();
    checks++;
    if (bus.CLASS_VALID !== 1'b0 || bus.CLASS_ID !== exp_id) begin
      failures++;
      $display("FAIL %s_valid_pulse valid=%b id=%0d required valid=0 id=%0d",
               tag, bus.CLASS_VALID, bus.CLASS_ID, exp_id);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b required=0", bus.AEROUT_ACK); end
    checks++;
    if (bus.CLASS_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b required=0", bus.CLASS_VALID); end
    checks++;
    if (bus.CLASS_ID !== '0) begin failures++; $display("FAIL rst_id got=%0d required=0", bus.CLASS_ID); end
    checks++;
    if (bus.CLASS_CNT !== '0) begin failures++; $display("FAIL rst_cnt got=%0d required=0", bus.CLASS_CNT); end
    checks++;
    if (bus.DROP_CNT !== 8'd0) begin failures++; $display("FAIL rst_drop got=%0d required=0", bus.DROP_CNT); end
    checks++;
    if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b required=0", bus.BUSY); end
  endtask

  task automatic test_single_event();
    pulse_clear();
    bus.AEROUT_ADDR = 12'd3;
    bus.AEROUT_REQ  = 1'b1;
    #1;
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin failures++; $display("FAIL single_ack_early got=%b required=0", bus.AEROUT_ACK); end
    tick();
    checks++;
    if (bus.AEROUT_ACK !== 1'b1 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL single_ack_rise ack=%b busy=%b required ack=1 busy=1", bus.AEROUT_ACK, bus.BUSY);
    end
    bus.AEROUT_ADDR = 12'd900;  // must be ignored while ACK is high
    tick();
    checks++;
    if (bus.AEROUT_ACK !== 1'b1) begin failures++; $display("FAIL single_ack_hold got=%b required=1", bus.AEROUT_ACK); end
    bus.AEROUT_REQ = 1'b0;
    tick();
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin failures++; $display("FAIL single_ack_fall got=%b required=0", bus.AEROUT_ACK); end
    tick();
    run_scan("single", 4'd3, 8'd1);
    checks++;
    if (bus.DROP_CNT !== 8'd0) begin failures++; $display("FAIL single_drop got=%0d required=0", bus.DROP_CNT); end
  endtask

  task automatic test_classify();
    pulse_clear();
    for (int i = 0; i < 5; i++) do_event(12'd7);
    for (int i = 0; i < 3; i++) do_event(12'd2);
    run_scan("classify", 4'd7, 8'd5);
  endtask

  task automatic test_tie_drop();
    pulse_clear();
    for (int i = 0; i < 4; i++) do_event(12'd1);
    for (int i = 0; i < 4; i++) do_event(12'd6);
    for (int i = 0; i < 2; i++) do_event(12'd900);
    run_scan("tie", 4'd1, 8'd4);
    checks++;
    if (bus.DROP_CNT !== 8'd2) begin failures++; $display("FAIL tie_drop got=%0d required=2", bus.DROP_CNT); end
  endtask

  task automatic test_saturation();
    pulse_clear();
    for (int i = 0; i < 300; i++) do_event(12'd0);
    run_scan("sat", 4'd0, 8'd255);
    checks++;
    if (bus.DROP_CNT !== 8'd0) begin failures++; $display("FAIL sat_drop got=%0d required=0", bus.DROP_CNT); end
  endtask

  task automatic test_collision();
    int  n;
    bit  early_ack;
    pulse_clear();
    for (int i = 0; i < 2; i++) do_event(12'd4);
    for (int i = 0; i < 3; i++) do_event(12'd5);
    bus.AEROUT_ADDR = 12'd4;
    bus.AEROUT_REQ  = 1'b1;
    tick();
    bus.SAMPLE_END = 1'b1;
    tick();
    bus.SAMPLE_END = 1'b0;
    checks++;
    if (bus.AEROUT_ACK !== 1'b1 || bus.BUSY !== 1'b1) begin
      failures++;
      $display("FAIL coll_ack_hold ack=%b busy=%b required ack=1 busy=1", bus.AEROUT_ACK, bus.BUSY);
    end
    bus.AEROUT_REQ = 1'b0;
    tick();
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin failures++; $display("FAIL coll_ack_fall got=%b required=0", bus.AEROUT_ACK); end
    tick();
    bus.AEROUT_ADDR = 12'd5;
    bus.AEROUT_REQ  = 1'b1;
    n = 0;
    early_ack = 1'b0;
    while (!bus.CLASS_VALID && n < 40) begin
      tick();
      n++;
      if (bus.AEROUT_ACK === 1'b1) early_ack = 1'b1;
    end
    checks++;
    if (early_ack !== 1'b0 || bus.CLASS_VALID !== 1'b1) begin
      failures++;
      $display("FAIL coll_req_blocked early_ack=%b valid=%b required early_ack=0 valid=1",
               early_ack, bus.CLASS_VALID);
    end
    checks++;
    if (bus.CLASS_ID !== 4'd4 || bus.CLASS_CNT !== 8'd3) begin
      failures++;
      $display("FAIL coll_result id=%0d cnt=%0d required id=4 cnt=3", bus.CLASS_ID, bus.CLASS_CNT);
    end
    tick();
    checks++;
    if (bus.AEROUT_ACK !== 1'b1) begin failures++; $display("FAIL coll_late_ack got=%b required=1", bus.AEROUT_ACK); end
    bus.AEROUT_REQ = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.AEROUT_ACK && n < 20);
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin failures++; $display("FAIL coll_late_fall got=%b required=0", bus.AEROUT_ACK); end
    run_scan("coll2", 4'd5, 8'd4);
  endtask

  task automatic test_clear_reset();
    int n;
    pulse_clear();
    do_event(12'd2);
    do_event(12'd2);
    do_event(12'd50);
    checks++;
    if (bus.DROP_CNT !== 8'd1) begin failures++; $display("FAIL clr_drop_pre got=%0d required=1", bus.DROP_CNT); end
    pulse_clear();
    checks++;
    if (bus.DROP_CNT !== 8'd0) begin failures++; $display("FAIL clr_drop_post got=%0d required=0", bus.DROP_CNT); end
    run_scan("clear", 4'd0, 8'd0);
    bus.AEROUT_ADDR = 12'd6;
    bus.AEROUT_REQ  = 1'b1;
    tick();
    checks++;
    if (bus.AEROUT_ACK !== 1'b1) begin failures++; $display("FAIL rstmid_ack_pre got=%b required=1", bus.AEROUT_ACK); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.AEROUT_ACK !== 1'b0 || bus.BUSY !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async ack=%b busy=%b required ack=0 busy=0", bus.AEROUT_ACK, bus.BUSY);
    end
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.AEROUT_ACK && n < 20);
    checks++;
    if (bus.AEROUT_ACK !== 1'b1) begin failures++; $display("FAIL rstmid_reack got=%b required=1", bus.AEROUT_ACK); end
    bus.AEROUT_REQ = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.AEROUT_ACK && n < 20);
    checks++;
    if (bus.AEROUT_ACK !== 1'b0) begin failures++; $display("FAIL rstmid_fall got=%b required=0", bus.AEROUT_ACK); end
    run_scan("rstmid", 4'd6, 8'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n           = 1'b0;
    bus.AEROUT_ADDR = '0;
    bus.AEROUT_REQ  = 1'b0;
    bus.CLEAR       = 1'b0;
    bus.SAMPLE_END  = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_single_event();
    test_classify();
    test_tie_drop();
    test_saturation();
    test_collision();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
